l2_dc_responder: RTL

L2-side responder for the L1 dcache miss/write-back interface. It accepts dcache requests, serves line fills (128-bit) from a backing-memory port, and absorbs dirty-line write-backs into a one-entry victim buffer. The victim buffer acknowledges immediately and drains to backing memory in the background. It sits between the dcache controller and the L2/memory backing port.

---
 rtl/dc_l2_pkg.sv | 21 ++
 rtl/l2_victim_buf.sv | 71 +++++++
 rtl/l2_dc_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dc_l2_pkg.sv
// Shared definitions for the L1 dcache / L2 responder interface.
package dc_l2_pkg;

  localparam int DC_ADDR_W = 28;
  localparam int DC_LINE_W = 128;

  // Encoding of l2_cache_rw_dc
  localparam logic DC_RW_READ = 1'b0;
  localparam logic DC_RW_WB   = 1'b1;

  // Main request FSM
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_WAIT = 3'd1,
    ST_WB_ACK  = 3'd2,
    ST_RD_MEM  = 3'd3,
    ST_FILL    = 3'd4,
    ST_DONE    = 3'd5
  } dc_state_e;

endpackage

// File: rtl/l2_victim_buf.sv
// One-entry victim buffer holding a dirty line until it has been written
// to backing memory. Exposes its next-state values so the parent can keep
// the backing-port outputs registered.
module l2_victim_buf
  import dc_l2_pkg::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int LINE_W = DC_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LINE_W-1:0] load_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic              mem_ack,
  input  logic              port_req,
  input  logic              port_we,
  output logic              vb_valid,
  output logic [LINE_W-1:0] vb_data,
  output logic              addr_match,
  output logic              drain_ack,
  output logic              drain_req_d,
  output logic [ADDR_W-1:0] drain_addr_d,
  output logic [LINE_W-1:0] drain_data_d
);

  logic              vb_valid_q, vb_valid_d;
  logic [ADDR_W-1:0] vb_addr_q, vb_addr_d;
  logic [LINE_W-1:0] vb_data_q, vb_data_d;

  // An ack only counts when our own write is the outstanding backing request
  assign drain_ack  = vb_valid_q & port_req & port_we & mem_ack;
  assign addr_match = vb_valid_q & (vb_addr_q == lookup_addr);
  assign vb_valid   = vb_valid_q;
  assign vb_data    = vb_data_q;

  assign drain_req_d  = vb_valid_d;
  assign drain_addr_d = vb_addr_d;
  assign drain_data_d = vb_data_d;

  // Next entry contents: a new load takes priority over the drain clear
  always_comb begin
    vb_valid_d = vb_valid_q;
    vb_addr_d  = vb_addr_q;
    vb_data_d  = vb_data_q;
    if (load) begin
      vb_valid_d = 1'b1;
      vb_addr_d  = load_addr;
      vb_data_d  = load_data;
    end else if (drain_ack) begin
      vb_valid_d = 1'b0;
    end else begin
      vb_valid_d = vb_valid_q;
    end
  end

  // Entry registers; reset discards any buffered dirty line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vb_valid_q <= 1'b0;
      vb_addr_q  <= '0;
      vb_data_q  <= '0;
    end else begin
      vb_valid_q <= vb_valid_d;
      vb_addr_q  <= vb_addr_d;
      vb_data_q  <= vb_data_d;
    end
  end

endmodule

// File: rtl/l2_dc_responder.sv
// L2-side responder for dcache line fills and dirty-line write-backs.
// Write-backs land in a one-entry victim buffer and are acknowledged at
// once; the buffer drains to backing memory in the background. All
// outputs are registered from next-state values.
module l2_dc_responder
  import dc_l2_pkg::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int LINE_W = DC_LINE_W,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drq,
  input  logic [ADDR_W-1:0] l2_addr_dc,
  input  logic              l2_cache_rw_dc,
  input  logic [LINE_W-1:0] rd_to_l2,
  input  logic              w_complete_dc,
  output logic              l2_rdy,
  output logic              dc_en,
  output logic              l2_complete_w,
  output logic [LINE_W-1:0] data_wd_l2,
  output logic              data_wd_l2_en,
  output logic              mem_wr_dc_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  dc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] data_wd_l2_q, data_wd_l2_d;
  logic              l2_rdy_q, l2_rdy_d;
  logic              dc_en_q, dc_en_d;
  logic              l2_complete_w_q, l2_complete_w_d;
  logic              fill_en_q, fill_en_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              vb_load;
  logic [ADDR_W-1:0] vb_load_addr;
  logic [LINE_W-1:0] vb_load_data;
  logic              vb_valid, vb_match, drain_ack, drain_req_d;
  logic [LINE_W-1:0] vb_data;
  logic [ADDR_W-1:0] drain_addr_d;
  logic [LINE_W-1:0] drain_data_d;
  logic              read_ack;

  l2_victim_buf #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_vb (
    .clk          (clk),
    .rst          (rst),
    .load         (vb_load),
    .load_addr    (vb_load_addr),
    .load_data    (vb_load_data),
    .lookup_addr  (l2_addr_dc),
    .mem_ack      (mem_ack),
    .port_req     (mem_req_q),
    .port_we      (mem_we_q),
    .vb_valid     (vb_valid),
    .vb_data      (vb_data),
    .addr_match   (vb_match),
    .drain_ack    (drain_ack),
    .drain_req_d  (drain_req_d),
    .drain_addr_d (drain_addr_d),
    .drain_data_d (drain_data_d)
  );

  // Stray acks (no read outstanding) are ignored
  assign read_ack = mem_ack & mem_req_q & ~mem_we_q;

  // Main FSM next state, request capture, victim-buffer loads and fill data
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_wd_l2_d = data_wd_l2_q;
    vb_load      = 1'b0;
    vb_load_addr = addr_q;
    vb_load_data = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (drq && l2_rdy_q) begin
          addr_d  = l2_addr_dc;
          wdata_d = rd_to_l2;
          case (l2_cache_rw_dc)
            DC_RW_WB: begin
              if (!vb_valid) begin
                vb_load      = 1'b1;
                vb_load_addr = l2_addr_dc;
                vb_load_data = rd_to_l2;
                state_d      = ST_WB_ACK;
              end else begin
                state_d = ST_WB_WAIT;
              end
            end
            DC_RW_READ: begin
              if (FWD_EN && vb_match) begin
                data_wd_l2_d = vb_data;
                state_d      = ST_FILL;
              end else begin
                state_d = ST_RD_MEM;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WB_WAIT: begin
        // Reload in the same edge the drain frees the entry
        if (!vb_valid || drain_ack) begin
          vb_load = 1'b1;
          state_d = ST_WB_ACK;
        end else begin
          state_d = ST_WB_WAIT;
        end
      end
      ST_WB_ACK: state_d = ST_DONE;
      ST_RD_MEM: begin
        if (read_ack) begin
          data_wd_l2_d = mem_rdata;
          state_d      = ST_FILL;
        end else begin
          state_d = ST_RD_MEM;
        end
      end
      ST_FILL: begin
        if (w_complete_dc) begin
          data_wd_l2_d = '0;
          state_d      = ST_DONE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values; the drain owns the backing port whenever the buffer
  // holds a line, so a read only issues once the buffer is empty
  always_comb begin
    l2_rdy_d        = (state_d == ST_IDLE);
    dc_en_d         = (state_d == ST_WB_WAIT) || (state_d == ST_WB_ACK) ||
                      (state_d == ST_RD_MEM)  || (state_d == ST_FILL);
    l2_complete_w_d = (state_d == ST_WB_ACK);
    fill_en_d       = (state_d == ST_FILL);
    mem_req_d       = 1'b0;
    mem_we_d        = 1'b0;
    mem_addr_d      = '0;
    mem_wdata_d     = '0;
    if (drain_req_d) begin
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = drain_addr_d;
      mem_wdata_d = drain_data_d;
    end else if (state_d == ST_RD_MEM) begin
      mem_req_d  = 1'b1;
      mem_addr_d = addr_d;
    end else begin
      mem_req_d = 1'b0;
    end
  end

  // State and output registers with asynchronous abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      data_wd_l2_q    <= '0;
      l2_rdy_q        <= 1'b0;
      dc_en_q         <= 1'b0;
      l2_complete_w_q <= 1'b0;
      fill_en_q       <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      data_wd_l2_q    <= data_wd_l2_d;
      l2_rdy_q        <= l2_rdy_d;
      dc_en_q         <= dc_en_d;
      l2_complete_w_q <= l2_complete_w_d;
      fill_en_q       <= fill_en_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  assign l2_rdy        = l2_rdy_q;
  assign dc_en         = dc_en_q;
  assign l2_complete_w = l2_complete_w_q;
  assign data_wd_l2    = data_wd_l2_q;
  assign data_wd_l2_en = fill_en_q;
  assign mem_wr_dc_en  = fill_en_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

endmodule
